// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/owner encodings and counter sizing shared by the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick_2.sv
// rr_pick_2: combinational 2-way round-robin picker; req[0] is CPU, req[1] is DMA
module rr_pick_2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       winner
);
  assign gnt_valid = |req;
  assign winner = &req ? ~last : (req[1] ? OWN_DMA : OWN_CPU);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port between CPU and DMA with a bounded-wait handshake
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic          dma_err,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = cnt_width(TIMEOUT);
  arb_state_t    r_state;
  logic          r_owner, r_last, r_first, r_we, r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_gnt_valid, w_winner, w_timeout, w_issue, w_resp, w_cpu_resp, w_dma_resp;
  rr_pick_2 u_pick (
    .req      ({dma_req, cpu_req}),
    .last     (r_last),
    .gnt_valid(w_gnt_valid),
    .winner   (w_winner)
  );
  // Fires on the edge closing the TIMEOUT-th ISSUE cycle
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_CPU;
      r_last  <= OWN_DMA;
      r_first <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (w_gnt_valid) begin
          r_state <= ARB_ISSUE;
          r_owner <= w_winner;
          r_last  <= w_winner;
          r_first <= 1'b1;
          r_we    <= w_winner ? dma_we : cpu_we;
          r_addr  <= w_winner ? dma_addr : cpu_addr;
          r_wdata <= w_winner ? dma_wdata : cpu_wdata;
          r_cnt   <= '0;
        end
        ARB_ISSUE: begin
          r_first <= 1'b0;
          if (mem_ready) begin
            r_state <= ARB_RESP;
            r_rdata <= r_we ? '0 : mem_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ARB_RESP;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ARB_RESP: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end
  assign w_issue    = r_state == ARB_ISSUE;
  assign w_resp     = r_state == ARB_RESP;
  assign w_cpu_resp = w_resp && r_owner == OWN_CPU;
  assign w_dma_resp = w_resp && r_owner == OWN_DMA;
  assign busy       = r_state != ARB_IDLE;
  assign mem_valid  = w_issue;
  assign mem_we     = w_issue && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_gnt    = w_issue && r_first && r_owner == OWN_CPU;
  assign dma_gnt    = w_issue && r_first && r_owner == OWN_DMA;
  assign cpu_done   = w_cpu_resp;
  assign dma_done   = w_dma_resp;
  assign cpu_err    = w_cpu_resp && r_err;
  assign dma_err    = w_dma_resp && r_err;
  assign cpu_rdata  = w_cpu_resp ? r_rdata : '0;
  assign dma_rdata  = w_dma_resp ? r_rdata : '0;
endmodule
